// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction-fetch / load-store memory port arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle; slave is the arbiter view, master the environment view.
interface mem_port_arbiter_if #(
  parameter int AW = mem_arb_pkg::AW_DEF,
  parameter int DW = mem_arb_pkg::DW_DEF
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;

  logic          ls_req_valid;
  logic          ls_req_ready;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_rsp_valid;
  logic [DW-1:0] ls_rsp_data;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, ls_req_valid, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr, ls_req_valid, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; grant is combinational, the last-grant pointer moves only when en_i grants.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  req_id_e last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == REQ_IF) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o[1]) last_d = REQ_LS;
      else if (gnt_o[0]) last_d = REQ_IF;
    end
  end

  // Reset to LS so the first conflict goes to instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_LS;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between fetch and load/store; one access in flight, 3 cycles per access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef struct packed {
    req_id_e       id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_e     state_q, state_d;
  req_t       req_q, req_d;
  logic [1:0] gnt;
  logic       arb_en;

  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({bus.ls_req_valid, bus.if_req_valid}),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    bus.if_req_ready = 1'b0;
    bus.ls_req_ready = 1'b0;
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_data  = '0;
    bus.ls_rsp_valid = 1'b0;
    bus.ls_rsp_data  = '0;
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    // Outputs stay quiet while reset is held, even if the state register has not cleared yet.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          bus.if_req_ready = gnt[0];
          bus.ls_req_ready = gnt[1];
          if (|gnt) begin
            req_d.id    = gnt[1] ? REQ_LS : REQ_IF;
            req_d.we    = gnt[1] & bus.ls_we;
            req_d.addr  = gnt[1] ? bus.ls_addr : bus.if_addr;
            req_d.wdata = gnt[1] ? bus.ls_wdata : '0;
            state_d     = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = req_q.we;
          bus.mem_addr  = req_q.addr;
          bus.mem_wdata = req_q.wdata;
          state_d       = ST_WAIT;
        end
        ST_WAIT: begin
          if (req_q.id == REQ_IF) begin
            bus.if_rsp_valid = 1'b1;
            bus.if_rsp_data  = bus.mem_rdata;
          end else begin
            bus.ls_rsp_valid = 1'b1;
            bus.ls_rsp_data  = req_q.we ? '0 : bus.mem_rdata;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM on the memory side.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = AW_DEF;
  localparam int DW = DW_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.if_req_valid = 1'b0;
    bus.if_addr      = '0;
    bus.ls_req_valid = 1'b0;
    bus.ls_we        = 1'b0;
    bus.ls_addr      = '0;
    bus.ls_wdata     = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    tick; tick;
    #1;
    n_tests++; if (bus.if_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %0h expected 0", bus.if_req_ready); end
    n_tests++; if (bus.ls_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ls_ready: got %0h expected 0", bus.ls_req_ready); end
    n_tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem_outputs: en=%0h we=%0h addr=%0h wdata=%0h expected all 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    n_tests++; if ({bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_rsp_data, bus.ls_rsp_data} !== '0) begin n_fail++; $display("FAIL reset_rsp_outputs: ifv=%0h lsv=%0h ifd=%0h lsd=%0h expected all 0", bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_rsp_data, bus.ls_rsp_data); end
    clear_inputs;
    rst = 1'b0;
  endtask

  task automatic test_ls_store_load;
    bus.ls_req_valid = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 10'h3FF; bus.ls_wdata = 19'h7FFFF;
    #1;
    n_tests++; if (bus.ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready: got %0h expected 1", bus.ls_req_ready); end
    tick;
    bus.ls_req_valid = 1'b0; bus.ls_wdata = '0; bus.ls_addr = '0;
    #1;
    n_tests++; if ({bus.mem_en, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL store_issue_en_we: got %0b expected 11", {bus.mem_en, bus.mem_we}); end
    n_tests++; if (bus.mem_addr !== 10'h3FF) begin n_fail++; $display("FAIL store_issue_addr: got %0h expected 3ff", bus.mem_addr); end
    n_tests++; if (bus.mem_wdata !== 19'h7FFFF) begin n_fail++; $display("FAIL store_issue_wdata: got %0h expected 7ffff", bus.mem_wdata); end
    tick; #1;
    n_tests++; if ({bus.ls_rsp_valid, bus.mem_en} !== 2'b10) begin n_fail++; $display("FAIL store_rsp_valid: rsp/en got %0b expected 10", {bus.ls_rsp_valid, bus.mem_en}); end
    n_tests++; if (bus.ls_rsp_data !== '0) begin n_fail++; $display("FAIL store_rsp_data: got %0h expected 0", bus.ls_rsp_data); end
    tick;
    bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h3FF;
    #1;
    n_tests++; if (bus.ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %0h expected 1", bus.ls_req_ready); end
    tick;
    bus.ls_req_valid = 1'b0;
    #1;
    n_tests++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin n_fail++; $display("FAIL load_issue_en_we: got %0b expected 10", {bus.mem_en, bus.mem_we}); end
    tick; #1;
    n_tests++; if ({bus.ls_rsp_valid, bus.if_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL load_rsp_valid: ls/if got %0b expected 10", {bus.ls_rsp_valid, bus.if_rsp_valid}); end
    n_tests++; if (bus.ls_rsp_data !== 19'h7FFFF) begin n_fail++; $display("FAIL load_rsp_data: got %0h expected 7ffff", bus.ls_rsp_data); end
    tick; #1;
    n_tests++; if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== '0) begin n_fail++; $display("FAIL load_rsp_after: valid=%0h data=%0h expected 0", bus.ls_rsp_valid, bus.ls_rsp_data); end
    clear_inputs;
  endtask

  task automatic test_if_read;
    bus.ls_req_valid = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 10'h005; bus.ls_wdata = 19'h1ABCD;
    tick;
    clear_inputs;
    tick; tick;
    bus.if_req_valid = 1'b1; bus.if_addr = 10'h005;
    #1;
    n_tests++; if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b10) begin n_fail++; $display("FAIL if_ready: if/ls got %0b expected 10", {bus.if_req_ready, bus.ls_req_ready}); end
    tick;
    bus.if_req_valid = 1'b0;
    #1;
    n_tests++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin n_fail++; $display("FAIL if_issue_en_we: got %0b expected 10", {bus.mem_en, bus.mem_we}); end
    n_tests++; if (bus.mem_addr !== 10'h005) begin n_fail++; $display("FAIL if_issue_addr: got %0h expected 5", bus.mem_addr); end
    tick; #1;
    n_tests++; if ({bus.if_rsp_valid, bus.ls_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL if_rsp_valid: if/ls got %0b expected 10", {bus.if_rsp_valid, bus.ls_rsp_valid}); end
    n_tests++; if (bus.if_rsp_data !== 19'h1ABCD) begin n_fail++; $display("FAIL if_rsp_data: got %0h expected 1abcd", bus.if_rsp_data); end
    tick;
    clear_inputs;
  endtask

  task automatic test_addr_hold;
    bus.if_req_valid = 1'b1; bus.if_addr = 10'h001;
    tick;
    bus.if_addr = 10'h002;
    #1;
    n_tests++; if (bus.mem_addr !== 10'h001) begin n_fail++; $display("FAIL addr_hold: got %0h expected 1", bus.mem_addr); end
    n_tests++; if (bus.if_req_ready !== 1'b0) begin n_fail++; $display("FAIL addr_hold_ready_issue: got %0h expected 0", bus.if_req_ready); end
    tick; #1;
    n_tests++; if ({bus.if_rsp_valid, bus.if_req_ready} !== 2'b10) begin n_fail++; $display("FAIL addr_hold_wait: rsp/ready got %0b expected 10", {bus.if_rsp_valid, bus.if_req_ready}); end
    bus.if_req_valid = 1'b0;
    tick;
    clear_inputs;
  endtask

  task automatic test_round_robin;
    req_id_e exp_id [4];
    req_id_e got_id [4];
    int      got_cyc [4];
    int      g = 0;
    int      both = 0;
    exp_id = '{REQ_IF, REQ_LS, REQ_IF, REQ_LS};
    rst = 1'b1;
    bus.if_req_valid = 1'b1; bus.if_addr = 10'h005;
    bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h3FF;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 30 && g < 4; c++) begin
      #1;
      if (bus.if_req_ready && bus.ls_req_ready) both++;
      else if (bus.if_req_ready || bus.ls_req_ready) begin
        got_id[g]  = bus.ls_req_ready ? REQ_LS : REQ_IF;
        got_cyc[g] = cyc;
        g++;
      end
      tick;
    end
    clear_inputs;
    n_tests++; if (g !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 4 within budget", g); end
    n_tests++; if (both !== 0) begin n_fail++; $display("FAIL rr_dual_ready: got %0d cycles expected 0", both); end
    for (int i = 0; i < g; i++) begin
      n_tests++; if (got_id[i] !== exp_id[i]) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, got_id[i], exp_id[i]); end
    end
    for (int i = 1; i < g; i++) begin
      n_tests++; if (got_cyc[i] - got_cyc[i-1] !== 3) begin n_fail++; $display("FAIL rr_spacing_%0d: got %0d expected 3", i, got_cyc[i] - got_cyc[i-1]); end
    end
    tick; tick;
  endtask

  task automatic test_back_to_back;
    int hs_cyc [3];
    int h = 0;
    int rsp_ok = 0;
    bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h3FF;
    for (int c = 0; c < 20 && h < 3; c++) begin
      #1;
      if (bus.ls_req_ready) begin hs_cyc[h] = cyc; h++; end
      if (bus.ls_rsp_valid && bus.ls_rsp_data === 19'h7FFFF) rsp_ok++;
      tick;
    end
    clear_inputs;
    n_tests++; if (h !== 3) begin n_fail++; $display("FAIL b2b_handshakes: got %0d expected 3 within budget", h); end
    for (int i = 1; i < h; i++) begin
      n_tests++; if (hs_cyc[i] - hs_cyc[i-1] !== 3) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d expected 3", i, hs_cyc[i] - hs_cyc[i-1]); end
    end
    n_tests++; if (rsp_ok !== 2) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d expected 2", rsp_ok); end
    tick; tick;
  endtask

  task automatic test_reset_abort;
    bus.if_req_valid = 1'b1; bus.if_addr = 10'h005;
    tick;
    bus.if_req_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    n_tests++; if ({bus.if_rsp_valid, bus.if_rsp_data} !== '0) begin n_fail++; $display("FAIL abort_wait_rsp: valid=%0h data=%0h expected 0", bus.if_rsp_valid, bus.if_rsp_data); end
    tick;
    rst = 1'b0;
    bus.if_req_valid = 1'b1;
    #1;
    n_tests++; if (bus.if_req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_if_ready_post: got %0h expected 1", bus.if_req_ready); end
    n_tests++; if ({bus.mem_en, bus.if_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_wait_quiet: en/rsp got %0b expected 00", {bus.mem_en, bus.if_rsp_valid}); end
    tick;
    bus.if_req_valid = 1'b0;
    tick; tick;
    bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h3FF;
    tick;
    bus.ls_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL abort_issue_en_in_rst: got %0h expected 0", bus.mem_en); end
    tick;
    rst = 1'b0;
    bus.ls_req_valid = 1'b1;
    #1;
    n_tests++; if (bus.ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ls_ready_post: got %0h expected 1", bus.ls_req_ready); end
    n_tests++; if ({bus.mem_en, bus.ls_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_issue_quiet: en/rsp got %0b expected 00", {bus.mem_en, bus.ls_rsp_valid}); end
    tick;
    bus.ls_req_valid = 1'b0;
    #1;
    n_tests++; if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL abort_reissue_en: got %0h expected 1", bus.mem_en); end
    tick; tick;
    clear_inputs;
  endtask

  initial begin
    clear_inputs;
    #1;
    test_reset;
    test_ls_store_load;
    test_if_read;
    test_addr_hold;
    test_round_robin;
    test_back_to_back;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 10: memory address width.
REQ-002 Parameter DW, default 19: memory data width, equal to the instruction word width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req_valid  input  1  instruction-fetch read request.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_addr  input  AW  fetch address.
REQ-008 if_rsp_valid  output  1  fetch data valid; one-cycle pulse.
REQ-009 if_rsp_data  output  DW  fetched word.
REQ-010 ls_req_valid  input  1  load/store request.
REQ-011 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-012 ls_we  input  1  1 = store, 0 = load.
REQ-013 ls_addr  input  AW  load/store address.
REQ-014 ls_wdata  input  DW  store data.
REQ-015 ls_rsp_valid  output  1  load data or store completion; one-cycle pulse.
REQ-016 ls_rsp_data  output  DW  load data; 0 for stores.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable, valid only while mem_en=1.
REQ-019 mem_addr  output  AW  memory address.
REQ-020 mem_wdata  output  DW  memory write data.
REQ-021 mem_rdata  input  DW  synchronous RAM read data, valid the cycle after mem_en.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT; exactly one access outstanding.
REQ-023 IDLE: x_req_ready=1 only for the winner among asserted valids; both readies 0 in ISSUE and WAIT.
REQ-024 Handshake (valid and ready in cycle N): register requester id, we, addr, wdata; go to ISSUE.
REQ-025 ISSUE (cycle N+1): mem_en=1, mem_we=we, mem_addr/mem_wdata from the registered request; go to WAIT.
REQ-026 WAIT (cycle N+2): winner's rsp_valid=1 and rsp_data=mem_rdata (load/fetch) or 0 (store); go to IDLE.
REQ-027 Throughput: one access per 3 cycles; next handshake no earlier than cycle N+3.
REQ-028 Arbitration: two-way round-robin; on simultaneous valids, the requester not granted last wins.
REQ-029 A lone valid requester wins regardless of the round-robin pointer.
REQ-030 Pointer updates only on handshake.
REQ-031 Request fields sampled only at handshake; changes afterward have no effect.
REQ-032 Outside ISSUE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Outside WAIT: both rsp_valid=0 and both rsp_data=0.
REQ-034 Fetch path never writes memory.

Reset
REQ-035 rst=1: state IDLE, all outputs 0, registered request cleared, pointer set so the first conflict grants IF.
REQ-036 rst asserted in ISSUE or WAIT aborts the access: no rsp_valid pulse; mem_en=0 from the next cycle.
REQ-037 Requests may be accepted in the first cycle after rst deasserts.

Structure
REQ-038 Shared package mem_arb_pkg holds the state enum, the requester-id encoding (IF=0, LS=1), and default AW/DW constants.
REQ-039 One sub-module rr_arb2: combinational 2-way round-robin picker with registered last-grant pointer.

Verification
REQ-040 IF-only read: mem[0x005]=0x1ABCD, if_addr=0x005 -> mem_en at N+1; if_rsp_valid and if_rsp_data=0x1ABCD at N+2.
REQ-041 LS store then load: store 0x7FFFF to 0x3FF, then load 0x3FF -> ls_rsp_data=0 on the store, 0x7FFFF on the load.
REQ-042 Both valid continuously from reset -> grants IF, LS, IF, LS; no requester granted twice in a row.
REQ-043 rst during WAIT of an IF read -> no if_rsp_valid; both readies 1 if valid on the first post-reset cycle.
REQ-044 if_addr changed 0x001->0x002 the cycle after handshake -> mem_addr=0x001.
REQ-045 Back-to-back LS: handshakes land at cycles N and N+3, never sooner.
